pht_ctrl: RTL and testbench

Controller that owns the single-port counter RAM of the pattern history table and schedules every access to it. After reset it initialises all counters with a sequential sweep. It then shares the one RAM port between the per-cycle prediction lookups from the fetch-side branch predictor and the read-modify-write counter updates reported by ID, which it buffers in a small queue. It sits between the BP stage, the ID-stage branch resolution and the PHT RAM macro.

---
 rtl/pht_pkg.sv | 31 +++
 rtl/pht_update_fifo.sv | 73 +++++++
 rtl/pht_ctrl.sv | 152 +++++++++++++++
 tb/tb_pht_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pht_pkg.sv
// Shared branch constants for the pattern history table: index width
// default, two-bit counter encoding and the saturating update rule.
package pht_pkg;

  localparam int GHR_WIDTH_DEF = 10;
  localparam int CTR_W         = 2;
  localparam int TAKEN_BIT     = CTR_W - 1;

  localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;  // weakly not-taken
  localparam logic [CTR_W-1:0] CTR_MIN  = 2'b00;
  localparam logic [CTR_W-1:0] CTR_MAX  = 2'b11;
  localparam logic [CTR_W-1:0] CTR_ONE  = 2'b01;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Saturating two-bit counter step: only overflow/underflow is clamped.
  function automatic logic [CTR_W-1:0] ctr_sat_next(input logic [CTR_W-1:0] ctr,
                                                    input logic             taken);
    logic [CTR_W-1:0] res;
    if (taken) begin
      res = (ctr == CTR_MAX) ? CTR_MAX : (ctr + CTR_ONE);
    end else begin
      res = (ctr == CTR_MIN) ? CTR_MIN : (ctr - CTR_ONE);
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_update_fifo.sv
// Small synchronous FIFO buffering {index, taken} counter updates until the
// RAM port is free. Flush empties it in one cycle.
module pht_update_fifo
  import pht_pkg::*;
#(
  parameter int IDX_W = GHR_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_taken,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_taken,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [IDX_W:0] mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push_s;
  logic           do_pop_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  assign head_idx   = mem_q[rd_ptr_q[AW-1:0]][IDX_W:1];
  assign head_taken = mem_q[rd_ptr_q[AW-1:0]][0];

  // Pointer next-state: flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
  end

  // Entry storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {push_idx, push_taken};
    end
  end

endmodule

// File: rtl/pht_ctrl.sv
// PHT counter RAM controller: initialisation sweep after reset, then
// arbitration of the single RAM port between prediction lookups and
// queued read-modify-write counter updates.
module pht_ctrl
  import pht_pkg::*;
#(
  parameter int GHR_WIDTH   = GHR_WIDTH_DEF,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid,
  input  logic [GHR_WIDTH-1:0] lookup_index,
  output logic                 lookup_ready,
  output logic                 pred_valid,
  output logic                 pred_taken,
  input  logic                 update_valid,
  input  logic [GHR_WIDTH-1:0] update_index,
  input  logic                 update_taken,
  output logic                 update_ready,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [GHR_WIDTH-1:0] mem_addr,
  output logic [CTR_W-1:0]     mem_wdata,
  input  logic [CTR_W-1:0]     mem_rdata
);

  localparam logic [GHR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [GHR_WIDTH-1:0] IDX_ONE  = {{(GHR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [GHR_WIDTH-1:0]  sweep_q, sweep_d;
  logic                  ph2_valid_q, ph2_valid_d;   // RMW write owed this cycle
  logic [GHR_WIDTH-1:0]  ph2_idx_q, ph2_idx_d;
  logic                  ph2_taken_q, ph2_taken_d;
  logic                  pred_valid_q, pred_valid_d;

  logic                  q_full_s, q_empty_s, q_pop_s, q_push_s, q_flush_s;
  logic [GHR_WIDTH-1:0]  q_head_idx_s;
  logic                  q_head_taken_s;
  logic                  mem_en_s, mem_we_s, lookup_ready_s;
  logic [GHR_WIDTH-1:0]  mem_addr_s;
  logic [CTR_W-1:0]      mem_wdata_s;

  assign q_flush_s    = !rst;
  assign busy         = (state_q == ST_INIT);
  assign update_ready = rst && (state_q == ST_RUN) && !q_full_s;
  assign q_push_s     = update_valid && update_ready;

  pht_update_fifo #(
    .IDX_W (GHR_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .flush      (q_flush_s),
    .push       (q_push_s),
    .push_idx   (update_index),
    .push_taken (update_taken),
    .pop        (q_pop_s),
    .head_idx   (q_head_idx_s),
    .head_taken (q_head_taken_s),
    .full       (q_full_s),
    .empty      (q_empty_s)
  );

  // FSM next state, sweep counter and RAM port arbitration.
  always_comb begin
    state_d        = state_q;
    sweep_d        = sweep_q;
    ph2_valid_d    = 1'b0;
    ph2_idx_d      = ph2_idx_q;
    ph2_taken_d    = ph2_taken_q;
    pred_valid_d   = 1'b0;
    q_pop_s        = 1'b0;
    mem_en_s       = 1'b0;
    mem_we_s       = 1'b0;
    mem_addr_s     = '0;
    mem_wdata_s    = 2'b00;
    lookup_ready_s = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_en_s    = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = sweep_q;
        mem_wdata_s = CTR_INIT;
        sweep_d     = sweep_q + IDX_ONE;
        if (sweep_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (ph2_valid_q) begin
          // Phase 2: the phase-1 read data is on mem_rdata now.
          mem_en_s    = 1'b1;
          mem_we_s    = 1'b1;
          mem_addr_s  = ph2_idx_q;
          mem_wdata_s = ctr_sat_next(mem_rdata, ph2_taken_q);
        end else if (lookup_valid && !q_full_s) begin
          mem_en_s       = 1'b1;
          mem_addr_s     = lookup_index;
          lookup_ready_s = 1'b1;
          pred_valid_d   = 1'b1;
        end else if (!q_empty_s) begin
          // Phase 1: a full queue also lands here, ahead of lookups.
          mem_en_s    = 1'b1;
          mem_addr_s  = q_head_idx_s;
          q_pop_s     = 1'b1;
          ph2_valid_d = 1'b1;
          ph2_idx_d   = q_head_idx_s;
          ph2_taken_d = q_head_taken_s;
        end else begin
          mem_en_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // State registers; reset aborts any RMW and restarts the sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      ph2_valid_q  <= 1'b0;
      ph2_idx_q    <= '0;
      ph2_taken_q  <= 1'b0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ph2_valid_q  <= ph2_valid_d;
      ph2_idx_q    <= ph2_idx_d;
      ph2_taken_q  <= ph2_taken_d;
      pred_valid_q <= pred_valid_d;
    end
  end

  assign mem_en       = mem_en_s && rst;
  assign mem_we       = mem_we_s && rst;
  assign mem_addr     = mem_addr_s;
  assign mem_wdata    = mem_wdata_s;
  assign lookup_ready = lookup_ready_s && rst;
  assign pred_valid   = pred_valid_q;
  assign pred_taken   = pred_valid_q && mem_rdata[TAKEN_BIT];

endmodule

// File: tb/tb_pht_ctrl.sv
// Directed bench for pht_ctrl with a 16-entry table and a behavioural RAM.
module tb_pht_ctrl;

  logic       clk;
  logic       rst;
  logic       lookup_valid;
  logic [3:0] lookup_index;
  logic       lookup_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic       update_valid;
  logic [3:0] update_index;
  logic       update_taken;
  logic       update_ready;
  logic       busy;
  logic       mem_en;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;

  logic [1:0] ram [16];
  logic [1:0] rdata_q;

  int total = 0;
  int bad   = 0;

  pht_ctrl #(
    .GHR_WIDTH   (4),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_index (lookup_index),
    .lookup_ready (lookup_ready),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .update_valid (update_valid),
    .update_index (update_index),
    .update_taken (update_taken),
    .update_ready (update_ready),
    .busy         (busy),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rdata_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant a lookup, then check the prediction in the following cycle.
  task automatic do_lookup(input logic [3:0] idx, input logic exp_taken);
    lookup_valid = 1'b1;
    lookup_index = idx;
    #1;
    chk("lk_ready", lookup_ready, 1);
    chk("lk_addr", mem_addr, idx);
    chk("lk_we", mem_we, 0);
    cyc();
    lookup_valid = 1'b0;
    #1;
    chk("lk_pvalid", pred_valid, 1);
    chk("lk_ptaken", pred_taken, exp_taken);
    cyc();
    chk("lk_pvalid_off", pred_valid, 0);
  endtask

  // One isolated update: enqueue, phase-1 read, phase-2 write.
  task automatic do_update(input logic [3:0] idx, input logic tk,
                           input logic [1:0] exp_old, input logic [1:0] exp_new);
    update_valid = 1'b1;
    update_index = idx;
    update_taken = tk;
    #1;
    chk("up_ready", update_ready, 1);
    chk("up_idle_enq", mem_en, 0);
    cyc();
    update_valid = 1'b0;
    #1;
    chk("up_rd_en", mem_en, 1);
    chk("up_rd_we", mem_we, 0);
    chk("up_rd_addr", mem_addr, idx);
    cyc();
    chk("up_wr_we", mem_we, 1);
    chk("up_wr_addr", mem_addr, idx);
    chk("up_old", mem_rdata, exp_old);
    chk("up_new", mem_wdata, exp_new);
    cyc();
    chk("up_idle_after", mem_en, 0);
  endtask

  initial begin
    rst = 1'b0; lookup_valid = 1'b0; lookup_index = 4'd0;
    update_valid = 1'b0; update_index = 4'd0; update_taken = 1'b0;
    cyc(); cyc();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 1);
    chk("rst_uready", update_ready, 0);
    chk("rst_lready", lookup_ready, 0);
    chk("rst_pvalid", pred_valid, 0);
    chk("rst_ptaken", pred_taken, 0);

    // Initialisation sweep: 16 writes of weakly-not-taken.
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("sw_en", mem_en, 1);
      chk("sw_we", mem_we, 1);
      chk("sw_addr", mem_addr, i);
      chk("sw_wdata", mem_wdata, 1);
      chk("sw_busy", busy, 1);
      chk("sw_uready", update_ready, 0);
      cyc();
    end
    chk("sw_busy_fall", busy, 0);
    chk("sw_idle", mem_en, 0);
    chk("sw_uready_run", update_ready, 1);
    for (int i = 0; i < 16; i++) chk("sw_ram", ram[i], 1);

    do_lookup(4'd5, 1'b0);

    // Taken saturation on index 3, then a not-taken step back.
    do_update(4'd3, 1'b1, 2'd1, 2'd2);
    do_update(4'd3, 1'b1, 2'd2, 2'd3);
    do_update(4'd3, 1'b1, 2'd3, 2'd3);
    do_lookup(4'd3, 1'b1);
    do_update(4'd3, 1'b0, 2'd3, 2'd2);
    chk("sat_ram3", ram[3], 2);

    // Queue saturation while lookups are held high.
    lookup_valid = 1'b1;
    lookup_index = 4'd9;
    for (int k = 0; k < 4; k++) begin
      update_valid = 1'b1;
      update_index = 4'(10 + k);
      update_taken = 1'b1;
      #1;
      chk("qs_uready", update_ready, 1);
      chk("qs_lready", lookup_ready, 1);
      chk("qs_laddr", mem_addr, 9);
      cyc();
    end
    update_valid = 1'b0;
    #1;
    chk("qs_full", update_ready, 0);
    chk("qs_rd_lready", lookup_ready, 0);
    chk("qs_rd_we", mem_we, 0);
    chk("qs_rd_addr", mem_addr, 10);
    cyc();
    chk("qs_wr_lready", lookup_ready, 0);
    chk("qs_wr_we", mem_we, 1);
    chk("qs_wr_addr", mem_addr, 10);
    chk("qs_wr_data", mem_wdata, 2);
    chk("qs_uready_back", update_ready, 1);
    cyc();
    chk("qs_pvalid_gap", pred_valid, 0);
    chk("qs_lk_again", lookup_ready, 1);
    chk("qs_lk_addr", mem_addr, 9);
    cyc();
    lookup_valid = 1'b0;
    #1;
    chk("qs_pvalid", pred_valid, 1);
    repeat (6) cyc();
    chk("qs_drained", mem_en, 0);
    for (int k = 10; k < 14; k++) chk("qs_ram", ram[k], 2);

    // Back-to-back updates to index 7: not-taken then taken.
    update_valid = 1'b1; update_index = 4'd7; update_taken = 1'b0;
    #1;
    cyc();
    update_taken = 1'b1;
    #1;
    chk("bb_rd1_we", mem_we, 0);
    chk("bb_rd1_addr", mem_addr, 7);
    chk("bb_uready", update_ready, 1);
    cyc();
    update_valid = 1'b0;
    #1;
    chk("bb_wr1_we", mem_we, 1);
    chk("bb_wr1_old", mem_rdata, 1);
    chk("bb_wr1_new", mem_wdata, 0);
    cyc();
    chk("bb_rd2_en", mem_en, 1);
    chk("bb_rd2_we", mem_we, 0);
    chk("bb_rd2_addr", mem_addr, 7);
    cyc();
    chk("bb_wr2_we", mem_we, 1);
    chk("bb_wr2_old", mem_rdata, 0);
    chk("bb_wr2_new", mem_wdata, 1);
    cyc();
    chk("bb_idle", mem_en, 0);
    chk("bb_ram7", ram[7], 1);

    // Reset asserted during phase 2 of an RMW with another update queued.
    update_valid = 1'b1; update_index = 4'd2; update_taken = 1'b1;
    #1;
    cyc();
    update_index = 4'd4;
    #1;
    chk("mr_rd_addr", mem_addr, 2);
    cyc();
    update_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_no_write", mem_en, 0);
    cyc();
    chk("mr_ram2", ram[2], 1);
    chk("mr_busy", busy, 1);
    chk("mr_uready", update_ready, 0);
    chk("mr_pvalid", pred_valid, 0);
    rst = 1'b1;
    #1;
    chk("mr_sw_en", mem_en, 1);
    chk("mr_sw_we", mem_we, 1);
    chk("mr_sw_addr0", mem_addr, 0);
    repeat (16) cyc();
    chk("mr_busy_fall", busy, 0);
    chk("mr_queue_empty", mem_en, 0);
    chk("mr_uready_run", update_ready, 1);
    do_lookup(4'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
